// File: rtl/boot_loader.sv
// Byte-stream program loader: writes a counted, checksummed image into memory
// and holds the CPU in reset until the image is verified.
// Ports: clk, reset (async, active-high)
//   rx_valid/rx_data/rx_ready : inbound byte stream
//   mem_addr/mem_wd/mem_wr    : memory write port
//   cpu_reset, done, error    : load status
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_wr,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] idx_nx;
  logic        accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_COUNT;
      n_q     <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs depend on state only, so rx_ready never sees rx_valid.
  assign rx_ready  = (state_q == S_COUNT) ||
                     (state_q == S_DATA)  ||
                     (state_q == S_CSUM);
  assign mem_wr    = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_reset = (state_q != S_DONE);
  assign mem_addr  = BASE_ADDR + (idx_q << 2);
  assign mem_wd    = word_q;

  assign accept = rx_valid && rx_ready;
  assign idx_nx = idx_q + 32'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_COUNT: begin
        if (accept) begin
          n_d    = {n_q[23:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (n_d > 32'(MAX_WORDS))
              state_d = S_ERR;
            else if (n_d == 32'd0)
              state_d = S_CSUM;
            else
              state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], rx_data};
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3)
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_nx;
        state_d = (idx_nx == n_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: vector tables for the per-cycle protocol
// plus hand-driven stall and async-reset sequences.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_wr;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_wr    (mem_wr),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        wr;
    logic [31:0] a;
    logic [31:0] w;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  vec_t vq[$];

  // write log filled by the monitor
  logic        mon_en = 1'b0;
  logic [31:0] log_a[$];
  logic [31:0] log_w[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d,
                     input logic rdy, input logic wr,
                     input logic [31:0] a, input logic [31:0] w,
                     input logic dn, input logic er, input logic cr);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.wr = wr;
    t.a = a; t.w = w; t.dn = dn; t.er = er; t.cr = cr;
    vq.push_back(t);
  endtask

  // receiving state: ready, nothing else
  task automatic rx(input logic [7:0] d);
    add(1'b1, d, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, ".ctl"}, {27'd0, rx_ready, mem_wr, done, error, cpu_reset},
        {27'd0, 5'b10001});
    chk({nm, ".addr"}, mem_addr, 32'h0);
    chk({nm, ".wd"}, mem_wd, 32'h0);
  endtask

  // Called at a negedge: each row drives the inputs for the coming
  // edge and checks the outputs of the current cycle.
  task automatic run_vecs(input string nm);
    for (int i = 0; i < vq.size(); i++) begin
      rx_valid = vq[i].v;
      rx_data  = vq[i].d;
      chk($sformatf("%s[%0d].ctl", nm, i),
          {27'd0, rx_ready, mem_wr, done, error, cpu_reset},
          {27'd0, vq[i].rdy, vq[i].wr, vq[i].dn, vq[i].er, vq[i].cr});
      if (vq[i].wr) begin
        chk($sformatf("%s[%0d].addr", nm, i), mem_addr, vq[i].a);
        chk($sformatf("%s[%0d].wd", nm, i), mem_wd, vq[i].w);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    vq.delete();
  endtask

  // Offer one byte until accepted, bounded.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && mem_wr) begin
      log_a.push_back(mem_addr);
      log_w.push_back(mem_wd);
    end
  end

  task automatic check_log(input string nm);
    chk({nm, ".nwr"}, 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk({nm, ".a0"}, log_a[0], 32'h0);
      chk({nm, ".w0"}, log_w[0], 32'h1234_5678);
      chk({nm, ".a1"}, log_a[1], 32'h4);
      chk({nm, ".w1"}, log_w[1], 32'hA5A5_0000);
    end
    chk({nm, ".end"}, {29'd0, done, error, cpu_reset}, 32'd4);
    log_a.delete();
    log_w.delete();
  endtask

  task automatic normal_body();
    rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h02);
    rx(8'h12); rx(8'h34); rx(8'h56); rx(8'h78);
    add(1'b1, 8'hA5, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    rx(8'hA5); rx(8'hA5); rx(8'h00); rx(8'h00);
    add(1'b1, 8'h08, 1'b0, 1'b1, 32'h4, 32'hA5A5_0000, 1'b0, 1'b0, 1'b1);
  endtask

  logic [7:0] img[13];
  int         ring;

  initial begin
    img = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
            8'hA5, 8'hA5, 8'h00, 8'h00, 8'h08};
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    // normal load
    normal_body();
    rx(8'h08);
    add(1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("normal");

    // empty image
    do_reset();
    rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h00);
    rx(8'h00);
    add(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("empty");

    // bad checksum
    do_reset();
    normal_body();
    rx(8'h09);
    add(1'b1, 8'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    run_vecs("badcsum");

    // oversize count, and MAX_WORDS itself is still legal
    do_reset();
    rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h41);
    add(1'b1, 8'h12, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h12, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    run_vecs("oversize");
    do_reset();
    rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h40);
    rx(8'h00);
    run_vecs("max64");

    // stalls: 3 idle cycles between bytes, ready low only in
    // write/done/error cycles
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(img[i]);
      repeat (3) begin
        chk("stall.rdy", {31'd0, rx_ready},
            {31'd0, !(mem_wr || done || error)});
        @(negedge clk);
      end
    end
    mon_en = 1'b0;
    check_log("stall");

    // async reset mid-load, then full replay
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) send(img[i]);
    chk("midrst.pre_wd", mem_wd, 32'h0000_1234);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    ring = 0;
    for (int i = 0; i < 13; i++) send(img[i]);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check_log("replay");

    // async reset out of the done state
    #2 reset = 1'b1;
    #1 check_reset_vals("donerst");
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
